// File: rtl/branch_resolve.sv
// Conditional-branch resolution: target compute, registered redirect,
// timed front-end flush window and saturating branch/taken counters.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [31:0]      br_pc,
    input  logic [15:0]      br_imm,
    input  logic             s,
    input  logic             stall,
    input  logic             cnt_clr,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             busy,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    localparam logic [2:0]       FC   = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t      state, state_n;
    logic [2:0]  left, left_n;
    logic        accept;
    logic        take;
    logic [31:0] target;

    assign accept = br_valid & ~stall & (state == IDLE);
    assign take   = accept & s;
    // imm is a word offset; target is relative to the next sequential pc
    assign target = br_pc + 32'd4 + {{14{br_imm[15]}}, br_imm, 2'b00};

    always_comb begin
        state_n = state;
        left_n  = left;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_n = FLUSH;
                    left_n  = FC;
                end
            end
            FLUSH: begin
                left_n = left - 3'd1;
                if (left == 3'd1) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            left        <= 3'd0;
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
            flush_if    <= 1'b0;
            flush_id    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state    <= state_n;
            left     <= left_n;
            redirect <= take;
            flush_if <= (state_n == FLUSH);
            flush_id <= (state_n == FLUSH);
            busy     <= (state_n == FLUSH);
            if (take) begin
                redirect_pc <= target;
            end
        end
    end

    // clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (cnt_clr) begin
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (accept && br_count != CMAX) begin
                br_count <= br_count + 1'b1;
            end
            if (take && taken_count != CMAX) begin
                taken_count <= taken_count + 1'b1;
            end
        end
    end

endmodule
